// File: rtl/conv_pkg.sv
// Shared types and frame geometry for the feature-map stream between conv layers.
// Latency: none (constants and types only).
// Backpressure: none (constants and types only).
//
// Contents: frame geometry (IMG_W x IMG_H), pixel width, count width,
// the signed pixel type and the streamer FSM state encoding.
package conv_pkg;

    localparam int IMG_W  = 24;
    localparam int IMG_H  = 32;
    localparam int DATA_W = 21;
    localparam int CNT_W  = 5;

    typedef logic signed [DATA_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } stream_state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster-order position tracker: column, row and linear buffer address.
// Latency: registered; new position is visible the cycle after advance_in.
// Backpressure: none; the owner decides when to advance or clear.
//
// Ports: clk_in/rst_in (async active-low), advance_in (step one pixel),
// clear_in (back to 0,0; wins over advance_in), h_out/v_out (column/row),
// addr_out (linear address), last_out (sitting on the final pixel of the frame).
module raster_counter #(
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 32,
    parameter int CNT_W  = 5,
    parameter int ADDR_W = 10
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              advance_in,
    input  logic              clear_in,
    output logic [CNT_W-1:0]  h_out,
    output logic [CNT_W-1:0]  v_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic              last_out
);

    logic [CNT_W-1:0]  h_q, h_d;
    logic [CNT_W-1:0]  v_q, v_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              row_end;

    assign row_end  = (h_q == CNT_W'(IMG_W - 1));
    assign last_out = row_end && (v_q == CNT_W'(IMG_H - 1));
    assign h_out    = h_q;
    assign v_out    = v_q;
    assign addr_out = addr_q;

    // The address walks alongside h/v instead of being rebuilt from v*IMG_W+h,
    // so no multiplier sits in the address path.
    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        addr_d = addr_q;
        if (clear_in) begin
            h_d    = '0;
            v_d    = '0;
            addr_d = '0;
        end else if (advance_in) begin
            addr_d = addr_q + ADDR_W'(1);
            if (row_end) begin
                h_d = '0;
                v_d = v_q + CNT_W'(1);
            end else begin
                h_d = h_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            h_q    <= '0;
            v_q    <= '0;
            addr_q <= '0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/feature_map_streamer.sv
// Streams one stored feature map out of a sync-read buffer in raster order, paced.
// Latency: first pixel strobe READ_LAT+1 cycles after start; one pixel every PIXEL_PERIOD cycles.
// Backpressure: none; fixed pacing, abort_in is the only way to stop a frame early.
//
// Ports: clk_in/rst_in (async active-low), start_in/abort_in (frame control),
// rd_addr_out/rd_data_in (buffer read port), pixel_data_out/hcount_out/
// vcount_out/data_valid_out (pixel stream), busy_out/done_out (frame status).
module feature_map_streamer #(
    parameter int IMG_W        = conv_pkg::IMG_W,
    parameter int IMG_H        = conv_pkg::IMG_H,
    parameter int DATA_W       = conv_pkg::DATA_W,
    parameter int CNT_W        = conv_pkg::CNT_W,
    parameter int ADDR_W       = 10,
    parameter int READ_LAT     = 2,
    parameter int PIXEL_PERIOD = 10
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     start_in,
    input  logic                     abort_in,
    output logic [ADDR_W-1:0]        rd_addr_out,
    input  logic signed [DATA_W-1:0] rd_data_in,
    output logic signed [DATA_W-1:0] pixel_data_out,
    output logic [CNT_W-1:0]         hcount_out,
    output logic [CNT_W-1:0]         vcount_out,
    output logic                     data_valid_out,
    output logic                     busy_out,
    output logic                     done_out
);

    import conv_pkg::*;

    localparam int PH_W = $clog2(PIXEL_PERIOD);

    stream_state_t state_q, state_d;
    logic [PH_W-1:0] ph_q, ph_d;

    logic [CNT_W-1:0]  h, v;
    logic [ADDR_W-1:0] addr;
    logic              last, advance, clear, pix_end, capture;

    logic signed [DATA_W-1:0] pix_q;
    logic [CNT_W-1:0]         hcnt_q, vcnt_q;
    logic                     dv_q, busy_q, done_q;

    raster_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .CNT_W  (CNT_W),
        .ADDR_W (ADDR_W)
    ) u_raster (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .advance_in (advance),
        .clear_in   (clear),
        .h_out      (h),
        .v_out      (v),
        .addr_out   (addr),
        .last_out   (last)
    );

    assign pix_end = (ph_q == PH_W'(PIXEL_PERIOD - 1));
    // Position is reset while parked so every frame starts at (0,0).
    assign clear   = (state_q == IDLE);
    // Address has been stable since ph==0, so the buffer output at ph==READ_LAT
    // belongs to the current pixel. An abort in that cycle suppresses the strobe.
    assign capture = (state_q == STREAM) && (ph_q == PH_W'(READ_LAT)) && !abort_in;

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                ph_d = '0;
                if (start_in && !abort_in) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (abort_in) begin
                    state_d = IDLE;
                end else if (pix_end) begin
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        ph_d    = '0;
                        advance = 1'b1;
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            ph_q    <= '0;
            pix_q   <= '0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            dv_q    <= capture;
            // Status flags follow the next state so they line up with state_q.
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            if (capture) begin
                pix_q  <= rd_data_in;
                hcnt_q <= h;
                vcnt_q <= v;
            end
        end
    end

    assign rd_addr_out    = addr;
    assign pixel_data_out = pix_q;
    assign hcount_out     = hcnt_q;
    assign vcount_out     = vcnt_q;
    assign data_valid_out = dv_q;
    assign busy_out       = busy_q;
    assign done_out       = done_q;

endmodule

// File: tb/tb_feature_map_streamer.sv
// Bench for feature_map_streamer: two instances (10-cycle and 4-cycle pacing) on a modelled sync-read buffer.
// Latency: buffer model returns data two cycles after the address.
// Backpressure: none.
module tb_feature_map_streamer;

    localparam int W  = 24;
    localparam int H  = 32;
    localparam int N  = W * H;
    localparam int L  = 2;
    localparam int PA = 10;
    localparam int PB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               start [2];
    logic               abort [2];
    logic [9:0]         addr  [2];
    logic signed [20:0] rdd   [2];
    logic signed [20:0] pix   [2];
    logic [4:0]         hc    [2];
    logic [4:0]         vc    [2];
    logic               dv    [2];
    logic               busy  [2];
    logic               done  [2];

    feature_map_streamer #(.READ_LAT(L), .PIXEL_PERIOD(PA)) dut_a (
        .clk_in(clk), .rst_in(rst_n), .start_in(start[0]), .abort_in(abort[0]),
        .rd_addr_out(addr[0]), .rd_data_in(rdd[0]), .pixel_data_out(pix[0]),
        .hcount_out(hc[0]), .vcount_out(vc[0]), .data_valid_out(dv[0]),
        .busy_out(busy[0]), .done_out(done[0])
    );

    feature_map_streamer #(.READ_LAT(L), .PIXEL_PERIOD(PB)) dut_b (
        .clk_in(clk), .rst_in(rst_n), .start_in(start[1]), .abort_in(abort[1]),
        .rd_addr_out(addr[1]), .rd_data_in(rdd[1]), .pixel_data_out(pix[1]),
        .hcount_out(hc[1]), .vcount_out(vc[1]), .data_valid_out(dv[1]),
        .busy_out(busy[1]), .done_out(done[1])
    );

    // Buffer: data appears two cycles after the address is presented.
    logic signed [20:0] mem    [1024];
    logic signed [20:0] stage1 [2];
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            stage1[i] <= mem[addr[i]];
            rdd[i]    <= stage1[i];
        end
    end

    // Reference: pixel n carries the stored word n at column n%W, row n/W.
    int expd [N];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                 t;
        logic signed [20:0] d;
        logic [4:0]         h;
        logic [4:0]         v;
    } strobe_t;

    strobe_t q0 [$];
    strobe_t q1 [$];

    int                 hold_err [2];
    int                 done_n   [2];
    int                 done_at  [2];
    int                 rise     [2];
    int                 fall     [2];
    logic               bprev    [2];
    logic signed [20:0] lp       [2];
    logic [4:0]         lh       [2];
    logic [4:0]         lv       [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                lp[i] <= '0;
                lh[i] <= '0;
                lv[i] <= '0;
            end else if (dv[i] === 1'b1) begin
                lp[i] <= pix[i];
                lh[i] <= hc[i];
                lv[i] <= vc[i];
                if (i == 0) q0.push_back('{cyc, pix[i], hc[i], vc[i]});
                else        q1.push_back('{cyc, pix[i], hc[i], vc[i]});
            end else if (pix[i] !== lp[i] || hc[i] !== lh[i] || vc[i] !== lv[i]) begin
                hold_err[i] <= hold_err[i] + 1;
            end
            if (done[i] === 1'b1) begin
                done_n[i]  <= done_n[i] + 1;
                done_at[i] <= cyc;
            end
            if (busy[i] === 1'b1 && bprev[i] === 1'b0) rise[i] <= cyc;
            if (busy[i] === 1'b0 && bprev[i] === 1'b1) fall[i] <= cyc;
            bprev[i] <= busy[i];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int qsize(input int i);
        if (i == 0) return q0.size();
        return q1.size();
    endfunction

    function automatic strobe_t qget(input int i, input int idx);
        if (i == 0) return q0[idx];
        return q1[idx];
    endfunction

    // mode 0: mem[a]=a-384, mode 1: constant, mode 2: random words.
    task automatic fill(input int mode, input logic signed [20:0] v);
        logic signed [20:0] x;
        for (int a = 0; a < 1024; a++) begin
            if (mode == 0)      x = 21'(a - 384);
            else if (mode == 1) x = v;
            else                x = 21'($urandom);
            mem[a] = x;
            if (a < N) expd[a] = int'(x);
        end
    endtask

    task automatic check_frame(input int i, input int p, input string nm,
                               input int qb, input int db, input int hb,
                               input longint f_exp, input longint l_exp);
        int k, n_got, lim, terr, derr, herr, verr;
        strobe_t s;
        k     = rise[i];
        n_got = qsize(i) - qb;
        chk({nm, " strobe count"}, n_got, N);
        lim  = (n_got < N) ? n_got : N;
        terr = 0; derr = 0; herr = 0; verr = 0;
        for (int n = 0; n < lim; n++) begin
            s = qget(i, qb + n);
            if (s.t != k + L + 1 + n * p) terr++;
            if (int'(s.d) != expd[n])     derr++;
            if (int'(s.h) != n % W)       herr++;
            if (int'(s.v) != n / W)       verr++;
        end
        chk({nm, " strobe timing errors"}, terr, 0);
        chk({nm, " data errors"}, derr, 0);
        chk({nm, " hcount errors"}, herr, 0);
        chk({nm, " vcount errors"}, verr, 0);
        if (n_got > 0) begin
            chk({nm, " first pixel"}, qget(i, qb).d, f_exp);
            chk({nm, " last pixel"}, qget(i, qsize(i) - 1).d, l_exp);
        end
        chk({nm, " done pulses"}, done_n[i] - db, 1);
        chk({nm, " done edge after start"}, done_at[i] - k, N * p);
        chk({nm, " busy length"}, fall[i] - k, N * p + 1);
        chk({nm, " hold errors"}, hold_err[i] - hb, 0);
    endtask

    task automatic run_frame(input int i, input int p, input string nm,
                             input longint f_exp, input longint l_exp, input int restarts);
        int qb, db, hb;
        qb = qsize(i); db = done_n[i]; hb = hold_err[i];
        @(posedge clk); #1 start[i] = 1'b1;
        for (int c = 0; c < N * p + 20; c++) begin
            @(posedge clk); #1;
            start[i] = (restarts != 0) && (c == 5 * p + 3 || c == 700 * p + 3);
        end
        check_frame(i, p, nm, qb, db, hb, f_exp, l_exp);
    endtask

    typedef struct {
        int                 mode;
        logic signed [20:0] fill;
        int                 dut;
        int                 restarts;
        longint             f_exp;
        longint             l_exp;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int qb, db, hb, got, d1;

        tbl[0] = '{0, 21'sd0,       0, 0, -384,     383};
        tbl[1] = '{1, 21'h1FFFFF,   0, 0, -1,       -1};
        tbl[2] = '{1, 21'h100000,   0, 0, -1048576, -1048576};
        tbl[3] = '{0, 21'sd0,       1, 0, -384,     383};
        tbl[4] = '{2, 21'sd0,       1, 1, 0,        0};

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            abort[i] = 1'b0;
        end
        fill(0, 21'sd0);

        // Reset state.
        #23;
        chk("reset rd_addr", addr[0], 0);
        chk("reset pixel", pix[0], 0);
        chk("reset hcount", hc[0], 0);
        chk("reset vcount", vc[0], 0);
        chk("reset valid", dv[0], 0);
        chk("reset busy", busy[0], 0);
        chk("reset done", done[0], 0);
        chk("reset busy b", busy[1], 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // start and abort together while idle: stays idle.
        @(posedge clk); #1 start[0] = 1'b1; abort[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0; abort[0] = 1'b0;
        chk("start+abort stays idle", busy[0], 0);

        // Table of full frames.
        for (int r = 0; r < 5; r++) begin
            fill(tbl[r].mode, tbl[r].fill);
            if (tbl[r].mode == 2)
                run_frame(tbl[r].dut, (tbl[r].dut == 0) ? PA : PB, $sformatf("vec%0d", r),
                          expd[0], expd[N-1], tbl[r].restarts);
            else
                run_frame(tbl[r].dut, (tbl[r].dut == 0) ? PA : PB, $sformatf("vec%0d", r),
                          tbl[r].f_exp, tbl[r].l_exp, tbl[r].restarts);
        end

        // Random contents, restart pulses at pixels 5 and 700 must be ignored.
        fill(2, 21'sd0);
        run_frame(0, PA, "rand restart", expd[0], expd[N-1], 1);

        // Abort at pixel 100, ph=3.
        fill(0, 21'sd0);
        qb = qsize(0); db = done_n[0];
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        got = 0;
        for (int c = 0; c < 1200; c++) begin
            @(posedge clk); #1;
            if (cyc == rise[0] + 100 * PA + 3) begin
                got = 1;
                break;
            end
        end
        chk("abort point reached", got, 1);
        chk("abort rd_addr", addr[0], 100);
        chk("abort pixel 100 data", pix[0], -284);
        chk("abort pixel 100 hcount", hc[0], 4);
        chk("abort pixel 100 vcount", vc[0], 4);
        chk("abort pixel 100 valid", dv[0], 1);
        abort[0] = 1'b1;
        @(posedge clk); #1 abort[0] = 1'b0;
        chk("abort busy low", busy[0], 0);
        chk("abort valid low", dv[0], 0);
        repeat (40) @(posedge clk);
        #1;
        chk("abort strobes", qsize(0) - qb, 101);
        chk("abort no done", done_n[0] - db, 0);
        run_frame(0, PA, "after abort", -384, 383, 0);

        // Asynchronous reset at pixel 300.
        qb = qsize(0); db = done_n[0];
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        got = 0;
        for (int c = 0; c < 3200; c++) begin
            @(posedge clk); #1;
            if (cyc == rise[0] + 300 * PA + 1) begin
                got = 1;
                break;
            end
        end
        chk("reset point reached", got, 1);
        chk("pre-reset rd_addr", addr[0], 300);
        rst_n = 1'b0;
        #2;
        chk("async reset rd_addr", addr[0], 0);
        chk("async reset pixel", pix[0], 0);
        chk("async reset hcount", hc[0], 0);
        chk("async reset vcount", vc[0], 0);
        chk("async reset valid", dv[0], 0);
        chk("async reset busy", busy[0], 0);
        chk("async reset done", done[0], 0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        qb = qsize(0);
        repeat (40) @(posedge clk);
        #1;
        chk("post-reset idle busy", busy[0], 0);
        chk("post-reset no strobes", qsize(0) - qb, 0);
        chk("post-reset no done", done_n[0] - db, 0);

        // start held through done_out: second frame follows immediately.
        qb = qsize(0); db = done_n[0]; hb = hold_err[0];
        @(posedge clk); #1 start[0] = 1'b1;
        got = 0;
        for (int c = 0; c < N * PA + 40; c++) begin
            @(posedge clk); #1;
            if (done_n[0] != db) begin
                got = 1;
                break;
            end
        end
        chk("b2b first done seen", got, 1);
        d1 = done_at[0];
        chk("b2b first strobes", qsize(0) - qb, N);
        repeat (4) @(posedge clk);
        #1 start[0] = 1'b0;
        repeat (N * PA + 20) @(posedge clk);
        #1;
        chk("b2b restart gap", rise[0] - d1, 2);
        check_frame(0, PA, "b2b second", qb + N, db + 1, hb, -384, 383);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
